// File: rtl/audio_gain_ramp_if.sv
// Sample/control bundle between the codec wrapper side and the ramped volume stage.
interface audio_gain_ramp_if #(
    parameter int DATA_W = 24,
    parameter int GAIN_W = 8
);
    logic [DATA_W-1:0] line_in_l;
    logic [DATA_W-1:0] line_in_r;
    logic              new_sample;
    logic [GAIN_W-1:0] target_gain;
    logic              mute;
    logic              clip_clr;
    logic [DATA_W-1:0] hphone_l;
    logic [DATA_W-1:0] hphone_r;
    logic              out_valid;
    logic [GAIN_W-1:0] cur_gain;
    logic              clip;

    modport master (
        output line_in_l, line_in_r, new_sample, target_gain, mute, clip_clr,
        input  hphone_l, hphone_r, out_valid, cur_gain, clip
    );

    modport slave (
        input  line_in_l, line_in_r, new_sample, target_gain, mute, clip_clr,
        output hphone_l, hphone_r, out_valid, cur_gain, clip
    );
endinterface

// File: rtl/audio_gain_ramp.sv
// Ramped digital volume stage: capture, multiply by Q1.7 gain, round half-up and saturate.
// Gain slews toward the (mute-aware) target by at most RAMP_STEP per accepted sample.
module audio_gain_ramp #(
    parameter int DATA_W    = 24,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 1
) (
    input logic              clk_48,
    input logic              rst_n,
    audio_gain_ramp_if.slave bus
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0]        STEP     = GAIN_W'(RAMP_STEP);
    localparam logic signed [PROD_W:0]   RND_BIAS = (PROD_W + 1)'(64);
    localparam logic signed [PROD_W:0]   MAX_V    = {{(PROD_W + 1 - DATA_W){1'b0}}, 1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PROD_W:0]   MIN_V    = {{(PROD_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic                     sampleValid_q;
    logic signed [DATA_W-1:0] sampleL_q, sampleR_q;
    logic [GAIN_W-1:0]        gain_q;
    logic [GAIN_W-1:0]        curGain_q, curGain_d;
    logic                     prodValid_q;
    logic signed [PROD_W-1:0] prodL_q, prodR_q, prodL_d, prodR_d;
    logic                     outValid_q;
    logic [DATA_W-1:0]        hphoneL_q, hphoneR_q, hphoneL_d, hphoneR_d;
    logic                     clip_q, clip_d;

    logic [GAIN_W-1:0]        effTgt, gap;
    logic signed [PROD_W:0]   roundSumL, roundSumR, roundL, roundR;
    logic                     satL, satR;

    // Slew limiter: moves by min(STEP, distance) so it can never overshoot or wrap.
    always_comb begin
        effTgt    = bus.mute ? '0 : bus.target_gain;
        gap       = '0;
        curGain_d = curGain_q;
        if (bus.new_sample) begin
            if (curGain_q < effTgt) begin
                gap       = effTgt - curGain_q;
                curGain_d = curGain_q + ((gap > STEP) ? STEP : gap);
            end else if (curGain_q > effTgt) begin
                gap       = curGain_q - effTgt;
                curGain_d = curGain_q - ((gap > STEP) ? STEP : gap);
            end
        end
    end

    always_comb begin
        prodL_d   = $signed(sampleL_q) * $signed({1'b0, gain_q});
        prodR_d   = $signed(sampleR_q) * $signed({1'b0, gain_q});
        roundSumL = {prodL_q[PROD_W-1], prodL_q} + RND_BIAS;
        roundSumR = {prodR_q[PROD_W-1], prodR_q} + RND_BIAS;
        roundL    = roundSumL >>> 7;
        roundR    = roundSumR >>> 7;
        satL      = (roundL > MAX_V) || (roundL < MIN_V);
        satR      = (roundR > MAX_V) || (roundR < MIN_V);
        hphoneL_d = (roundL > MAX_V) ? MAX_V[DATA_W-1:0] :
                    (roundL < MIN_V) ? MIN_V[DATA_W-1:0] : roundL[DATA_W-1:0];
        hphoneR_d = (roundR > MAX_V) ? MAX_V[DATA_W-1:0] :
                    (roundR < MIN_V) ? MIN_V[DATA_W-1:0] : roundR[DATA_W-1:0];
        // A saturation landing in the same cycle as a clear must leave clip set.
        if (prodValid_q && (satL || satR)) begin
            clip_d = 1'b1;
        end else if (bus.clip_clr) begin
            clip_d = 1'b0;
        end else begin
            clip_d = clip_q;
        end
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            sampleValid_q <= 1'b0;
            sampleL_q     <= '0;
            sampleR_q     <= '0;
            gain_q        <= '0;
            curGain_q     <= '0;
            prodValid_q   <= 1'b0;
            prodL_q       <= '0;
            prodR_q       <= '0;
            outValid_q    <= 1'b0;
            hphoneL_q     <= '0;
            hphoneR_q     <= '0;
            clip_q        <= 1'b0;
        end else begin
            sampleValid_q <= bus.new_sample;
            if (bus.new_sample) begin
                sampleL_q <= bus.line_in_l;
                sampleR_q <= bus.line_in_r;
                gain_q    <= curGain_q;
            end
            curGain_q   <= curGain_d;
            prodValid_q <= sampleValid_q;
            prodL_q     <= prodL_d;
            prodR_q     <= prodR_d;
            outValid_q  <= prodValid_q;
            if (prodValid_q) begin
                hphoneL_q <= hphoneL_d;
                hphoneR_q <= hphoneR_d;
            end
            clip_q <= clip_d;
        end
    end

    assign bus.hphone_l  = hphoneL_q;
    assign bus.hphone_r  = hphoneR_q;
    assign bus.out_valid = outValid_q;
    assign bus.cur_gain  = curGain_q;
    assign bus.clip      = clip_q;

endmodule

// File: tb/tb_audio_gain_ramp.sv
// Bench for audio_gain_ramp: table vectors plus ramp/clip/reset sequences, outputs scored via queue.
module tb_audio_gain_ramp;

    logic clk48 = 1'b0;
    logic rstN  = 1'b0;
    always #5 clk48 = ~clk48;

    audio_gain_ramp_if #(.DATA_W(24), .GAIN_W(8)) busMain ();
    audio_gain_ramp_if #(.DATA_W(24), .GAIN_W(8)) busStep4 ();

    audio_gain_ramp #(.DATA_W(24), .GAIN_W(8), .RAMP_STEP(1)) dut (
        .clk_48(clk48),
        .rst_n (rstN),
        .bus   (busMain)
    );

    audio_gain_ramp #(.DATA_W(24), .GAIN_W(8), .RAMP_STEP(4)) dutStep4 (
        .clk_48(clk48),
        .rst_n (rstN),
        .bus   (busStep4)
    );

    typedef struct {
        logic [23:0] expL;
        logic [23:0] expR;
        int          strobeCycle;
    } sbEntry_t;

    typedef struct {
        int          gain;
        logic [23:0] inL;
        logic [23:0] inR;
        logic [23:0] expL;
        logic [23:0] expR;
        bit          expSat;
    } vector_t;

    sbEntry_t sbQ[$];
    sbEntry_t monEntry;
    int vectorCount = 0;
    int missCount   = 0;
    int cycleCount  = 0;
    int modelGain   = 0;
    int modelGain4  = 0;

    always @(posedge clk48) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    function automatic int nextGain(input int cur, input int tgt, input int step);
        if (cur < tgt) return cur + ((tgt - cur > step) ? step : tgt - cur);
        if (cur > tgt) return cur - ((cur - tgt > step) ? step : cur - tgt);
        return cur;
    endfunction

    // Floor division written out explicitly rather than via an arithmetic shift.
    function automatic logic [23:0] expectOut(input logic [23:0] x, input int g);
        longint n;
        longint q;
        n = longint'($signed(x)) * longint'(g) + 64;
        q = n / 128;
        if ((n % 128 != 0) && (n < 0)) q = q - 1;
        if (q > 8388607)  q = 8388607;
        if (q < -8388608) q = -8388608;
        return q[23:0];
    endfunction

    always @(negedge clk48) begin
        if (rstN && busMain.out_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("spuriousOutValid", 32'd1, 32'd0);
            end else begin
                monEntry = sbQ.pop_front();
                checkOutput("hphoneL", 32'(busMain.hphone_l), 32'(monEntry.expL));
                checkOutput("hphoneR", 32'(busMain.hphone_r), 32'(monEntry.expR));
                checkOutput("latency", 32'(cycleCount - monEntry.strobeCycle), 32'd3);
            end
        end
    end

    // Called at a negedge; strobes for one cycle and returns at the following negedge.
    task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r,
                                 input logic [23:0] expL, input logic [23:0] expR);
        sbEntry_t e;
        busMain.line_in_l  = l;
        busMain.line_in_r  = r;
        busMain.new_sample = 1'b1;
        e.expL        = expL;
        e.expR        = expR;
        e.strobeCycle = cycleCount;
        sbQ.push_back(e);
        modelGain = nextGain(modelGain, busMain.mute ? 0 : int'(busMain.target_gain), 1);
        @(negedge clk48);
        busMain.new_sample = 1'b0;
        checkOutput("curGain", 32'(busMain.cur_gain), 32'(modelGain));
    endtask

    task automatic applyModel(input logic [23:0] l, input logic [23:0] r);
        applyStimulus(l, r, expectOut(l, modelGain), expectOut(r, modelGain));
    endtask

    task automatic rampTo(input int g);
        busMain.target_gain = 8'(g);
        for (int i = 0; i < 300 && modelGain != g; i++) applyModel(24'h0, 24'h0);
    endtask

    task automatic drainPipe();
        for (int i = 0; i < 10 && sbQ.size() != 0; i++) @(negedge clk48);
        checkOutput("pipeDrained", 32'(sbQ.size()), 32'd0);
    endtask

    task automatic applyStep4();
        busStep4.new_sample = 1'b1;
        modelGain4 = nextGain(modelGain4, busStep4.mute ? 0 : int'(busStep4.target_gain), 4);
        @(negedge clk48);
        busStep4.new_sample = 1'b0;
        checkOutput("curGainStep4", 32'(busStep4.cur_gain), 32'(modelGain4));
    endtask

    task automatic checkResetState();
        checkOutput("rstHphoneL", 32'(busMain.hphone_l), 32'd0);
        checkOutput("rstHphoneR", 32'(busMain.hphone_r), 32'd0);
        checkOutput("rstOutValid", 32'(busMain.out_valid), 32'd0);
        checkOutput("rstCurGain", 32'(busMain.cur_gain), 32'd0);
        checkOutput("rstClip", 32'(busMain.clip), 32'd0);
        checkOutput("rstCurGainStep4", 32'(busStep4.cur_gain), 32'd0);
    endtask

    vector_t vectors[9];
    bit      stickySat;
    bit      seenValid;

    initial begin
        vectors[0] = '{128, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 1'b0};
        vectors[1] = '{128, 24'h123456, 24'hFFFFFB, 24'h123456, 24'hFFFFFB, 1'b0};
        vectors[2] = '{64,  24'h000003, 24'hFFFFFD, 24'h000002, 24'hFFFFFF, 1'b0};
        vectors[3] = '{64,  24'h000001, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b0};
        vectors[4] = '{255, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 1'b1};
        vectors[5] = '{255, 24'h010000, 24'h000000, 24'h01FE00, 24'h000000, 1'b0};
        vectors[6] = '{0,   24'h7FFFFF, 24'h800000, 24'h000000, 24'h000000, 1'b0};
        vectors[7] = '{192, 24'h400000, 24'hC00000, 24'h600000, 24'hA00000, 1'b0};
        vectors[8] = '{200, 24'h600000, 24'h000000, 24'h7FFFFF, 24'h000000, 1'b1};

        busMain.line_in_l   = '0;
        busMain.line_in_r   = '0;
        busMain.new_sample  = 1'b0;
        busMain.target_gain = '0;
        busMain.mute        = 1'b0;
        busMain.clip_clr    = 1'b0;
        busStep4.line_in_l   = '0;
        busStep4.line_in_r   = '0;
        busStep4.new_sample  = 1'b0;
        busStep4.target_gain = '0;
        busStep4.mute        = 1'b0;
        busStep4.clip_clr    = 1'b0;

        repeat (3) @(negedge clk48);
        checkResetState();
        rstN = 1'b1;
        @(negedge clk48);
        checkResetState();

        $display("[TB] soft start ramp to unity");
        busMain.target_gain = 8'd128;
        for (int i = 0; i < 200; i++) applyModel(24'h100000, 24'h100000);
        drainPipe();
        checkOutput("clipAfterRamp", 32'(busMain.clip), 32'd0);

        $display("[TB] table vectors");
        stickySat = 1'b0;
        for (int v = 0; v < 9; v++) begin
            rampTo(vectors[v].gain);
            applyStimulus(vectors[v].inL, vectors[v].inR, vectors[v].expL, vectors[v].expR);
            drainPipe();
            stickySat = stickySat | vectors[v].expSat;
            checkOutput("clipSticky", 32'(busMain.clip), 32'(stickySat));
        end

        $display("[TB] clip clear and set-wins");
        busMain.clip_clr = 1'b1;
        @(negedge clk48);
        busMain.clip_clr = 1'b0;
        checkOutput("clipCleared", 32'(busMain.clip), 32'd0);
        busMain.clip_clr = 1'b1;
        applyStimulus(24'h7FFFFF, 24'h000000, 24'h7FFFFF, 24'h000000);
        seenValid = 1'b0;
        for (int i = 0; i < 10 && !seenValid; i++) begin
            if (busMain.out_valid) seenValid = 1'b1;
            else @(negedge clk48);
        end
        checkOutput("satOutValidSeen", 32'(seenValid), 32'd1);
        checkOutput("clipSetWins", 32'(busMain.clip), 32'd1);
        @(negedge clk48);
        checkOutput("clipClearAfterSat", 32'(busMain.clip), 32'd0);
        busMain.clip_clr = 1'b0;

        $display("[TB] back-to-back strobes");
        rampTo(128);
        for (int i = 0; i < 6; i++) applyModel(24'(i * 24'h011111), 24'(24'h800000 + i * 3));
        drainPipe();

        $display("[TB] step-4 ramp and mute");
        busStep4.target_gain = 8'd128;
        for (int i = 0; i < 32; i++) applyStep4();
        busStep4.mute = 1'b1;
        for (int i = 0; i < 17; i++) applyStep4();
        checkOutput("step4At60", 32'(busStep4.cur_gain), 32'd60);
        busStep4.mute        = 1'b0;
        busStep4.target_gain = 8'd62;
        applyStep4();
        applyStep4();
        checkOutput("step4Clamp62", 32'(busStep4.cur_gain), 32'd62);
        repeat (5) @(negedge clk48);
        checkOutput("step4HoldIdle", 32'(busStep4.cur_gain), 32'd62);
        busStep4.mute = 1'b1;
        for (int i = 0; i < 17; i++) applyStep4();
        checkOutput("step4MuteFloor", 32'(busStep4.cur_gain), 32'd0);

        $display("[TB] reset with samples in flight");
        applyModel(24'h123456, 24'h654321);
        applyModel(24'h0ABCDE, 24'h0EDCBA);
        rstN = 1'b0;
        repeat (3) @(negedge clk48);
        sbQ.delete();
        modelGain  = 0;
        modelGain4 = 0;
        checkResetState();
        rstN = 1'b1;
        repeat (8) @(negedge clk48);
        checkResetState();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
